// File: rtl/riscv_multicycle_ctrl_if.sv
// Control-path bundle between the RV32I multicycle datapath and its controller.
// Instruction fields and the ALU zero flag flow into the controller; datapath
// control lines flow out of it.
//   master : datapath side (drives instruction fields / zero flag)
//   slave  : controller side (drives control lines)
// Optional macro CTRL_MEM_WAIT_EN adds i_mem_ready (memory handshake).
interface riscv_multicycle_ctrl_if;
    logic [6:0] i_op;
    logic [2:0] i_funct3;
    logic       i_funct7b5;
    logic       i_zero;
`ifdef CTRL_MEM_WAIT_EN
    logic       i_mem_ready;
`endif
    logic       o_pc_write;
    logic       o_adr_src;
    logic       o_ir_write;
    logic       o_mem_write;
    logic       o_reg_write;
    logic [1:0] o_result_src;
    logic [1:0] o_alu_src_a;
    logic [1:0] o_alu_src_b;
    logic [2:0] o_alu_control;
    logic [1:0] o_imm_src;
    logic       o_illegal;
    logic [3:0] o_state;

`ifdef CTRL_MEM_WAIT_EN
    modport master (
        output i_op, i_funct3, i_funct7b5, i_zero, i_mem_ready,
        input  o_pc_write, o_adr_src, o_ir_write, o_mem_write, o_reg_write, o_result_src,
               o_alu_src_a, o_alu_src_b, o_alu_control, o_imm_src, o_illegal, o_state
    );
    modport slave (
        input  i_op, i_funct3, i_funct7b5, i_zero, i_mem_ready,
        output o_pc_write, o_adr_src, o_ir_write, o_mem_write, o_reg_write, o_result_src,
               o_alu_src_a, o_alu_src_b, o_alu_control, o_imm_src, o_illegal, o_state
    );
`else
    modport master (
        output i_op, i_funct3, i_funct7b5, i_zero,
        input  o_pc_write, o_adr_src, o_ir_write, o_mem_write, o_reg_write, o_result_src,
               o_alu_src_a, o_alu_src_b, o_alu_control, o_imm_src, o_illegal, o_state
    );
    modport slave (
        input  i_op, i_funct3, i_funct7b5, i_zero,
        output o_pc_write, o_adr_src, o_ir_write, o_mem_write, o_reg_write, o_result_src,
               o_alu_src_a, o_alu_src_b, o_alu_control, o_imm_src, o_illegal, o_state
    );
`endif
endinterface

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle control FSM for the RV32I core (lw/sw/R/I-ALU/jal/beq).
// Sequences the datapath one state per cycle and drives its control lines.
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : asynchronous active-high reset (state -> FETCH, writes suppressed)
//   bus    : riscv_multicycle_ctrl_if.slave (instruction fields in, control lines out)
// Parameter TRAP_ON_ILLEGAL: 1 = unknown opcode enters sticky TRAP, 0 = treated as NOP.
// Optional macro CTRL_MEM_WAIT_EN: FETCH/MEMREAD/MEMWRITE wait for bus.i_mem_ready.
module riscv_multicycle_ctrl #(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    riscv_multicycle_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
        S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_ALUWB = 4'd7,
        S_EXECI = 4'd8, S_JAL = 4'd9, S_BEQ = 4'd10, S_TRAP = 4'd11
    } state_t;

    localparam logic [1:0] ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_R = 2'b10;

    state_t     state, state_nxt;
    logic       mem_rdy;
    logic       pc_update, branch, ir_write, mem_write, reg_write, adr_src;
    logic [1:0] result_src, src_a, src_b, alu_op, imm_src;
    logic [2:0] alu_control;

`ifdef CTRL_MEM_WAIT_EN
    assign mem_rdy = bus.i_mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = S_FETCH;
        pc_update  = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        adr_src    = 1'b0;
        result_src = 2'b00;
        src_a      = 2'b00;
        src_b      = 2'b00;
        alu_op     = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                // PC+4 goes straight to PC via the combinational ALU result
                src_b      = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_rdy;
                pc_update  = mem_rdy;
                state_nxt  = mem_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // OldPC + imm precomputes the branch target into ALUOut
                src_a = 2'b01;
                src_b = 2'b01;
                case (bus.i_op)
                    7'b0000011, 7'b0100011: state_nxt = S_MEMADR;
                    7'b0110011:             state_nxt = S_EXECR;
                    7'b0010011:             state_nxt = S_EXECI;
                    7'b1101111:             state_nxt = S_JAL;
                    7'b1100011:             state_nxt = S_BEQ;
                    default:                state_nxt = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
                endcase
            end
            S_MEMADR: begin
                src_a     = 2'b10;
                src_b     = 2'b01;
                // op[5] separates sw (0100011) from lw (0000011)
                state_nxt = bus.i_op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src   = 1'b1;
                state_nxt = mem_rdy ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                state_nxt = mem_rdy ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                src_a     = 2'b10;
                alu_op    = ALUOP_R;
                state_nxt = S_ALUWB;
            end
            S_EXECI: begin
                src_a     = 2'b10;
                src_b     = 2'b01;
                alu_op    = ALUOP_R;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: reg_write = 1'b1;
            S_JAL: begin
                // rd <= OldPC+4 via ALUWB; PC <= target held in ALUOut
                src_a     = 2'b01;
                src_b     = 2'b10;
                pc_update = 1'b1;
                state_nxt = S_ALUWB;
            end
            S_BEQ: begin
                src_a  = 2'b10;
                alu_op = ALUOP_SUB;
                branch = 1'b1;
            end
            S_TRAP:  state_nxt = S_TRAP;
            default: state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        alu_control = 3'b000;
        case (alu_op)
            ALUOP_SUB: alu_control = 3'b001;
            ALUOP_R: begin
                case (bus.i_funct3)
                    // sub only for register-register; addi ignores bit 30
                    3'b000:  alu_control = (bus.i_op[5] & bus.i_funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default: alu_control = 3'b000;
        endcase
    end

    always_comb begin
        case (bus.i_op)
            7'b0100011: imm_src = 2'b01;
            7'b1100011: imm_src = 2'b10;
            7'b1101111: imm_src = 2'b11;
            default:    imm_src = 2'b00;
        endcase
    end

    // Write strobes are gated by reset so an aborted instruction never commits
    assign bus.o_pc_write    = ~i_rst & (pc_update | (branch & bus.i_zero));
    assign bus.o_ir_write    = ~i_rst & ir_write;
    assign bus.o_mem_write   = ~i_rst & mem_write;
    assign bus.o_reg_write   = ~i_rst & reg_write;
    assign bus.o_adr_src     = adr_src;
    assign bus.o_result_src  = result_src;
    assign bus.o_alu_src_a   = src_a;
    assign bus.o_alu_src_b   = src_b;
    assign bus.o_alu_control = alu_control;
    assign bus.o_imm_src     = imm_src;
    assign bus.o_illegal     = (state == S_TRAP);
    assign bus.o_state       = state;
endmodule
